// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU register-file slice: write-op encodings and
// the flag bundle carried by the live and shadow banks.
package cpu_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_INC  = 2'b01,
      OP_DEC  = 2'b10,
      OP_CLR  = 2'b11
   } op_e;

   typedef struct packed {
      logic zero;
      logic carry;
   } flags_t;

endpackage

// File: rtl/cpu_reg_update.sv
// Combinational register update: applies one write op to the current value and
// derives the zero/carry flags of the result.
module cpu_reg_update
   import cpu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] cur_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             carry_o
);

   // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      result_o = cur_i;
      carry_o  = 1'b0;
      case (op_e'(op_i))
         OP_LOAD: result_o = data_i;
         OP_INC:  {carry_o, result_o} = {1'b0, cur_i} + (WIDTH+1)'(1);
         OP_DEC: begin
            result_o = cur_i - WIDTH'(1);
            carry_o  = (cur_i == '0);
         end
         OP_CLR:  result_o = '0;
         default: result_o = cur_i;
      endcase
      zero_o = (result_o == '0);
   end

endmodule

// File: rtl/cpu_register_file.sv
// DEPTH x WIDTH register file with one in-place-op write port, two combinational
// read ports, zero/carry flags and a one-deep shadow bank for context save/restore.
module cpu_register_file
   import cpu_pkg::*;
#(
   parameter  int WIDTH  = 8,
   parameter  int DEPTH  = 4,
   parameter  int BYPASS = 1,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [1:0]       wr_op,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_a_addr,
   output logic [WIDTH-1:0] rd_a_data,
   input  logic [AW-1:0]    rd_b_addr,
   output logic [WIDTH-1:0] rd_b_data,
   input  logic             ctx_save,
   input  logic             ctx_restore,
   output logic             ctx_valid,
   output logic             ctx_err,
   output logic             flag_zero,
   output logic             flag_carry
);

   logic [WIDTH-1:0] live_q   [DEPTH];
   logic [WIDTH-1:0] live_d   [DEPTH];
   logic [WIDTH-1:0] shadow_q [DEPTH];
   logic [WIDTH-1:0] shadow_d [DEPTH];
   flags_t           flags_q, flags_d;
   flags_t           shadow_flags_q, shadow_flags_d;
   logic             ctx_valid_q, ctx_valid_d;
   logic             ctx_err_q, ctx_err_d;

   logic             wr_hit;
   logic             do_restore;
   logic [WIDTH-1:0] wr_cur;
   logic [WIDTH-1:0] upd_result;
   logic             upd_zero;
   logic             upd_carry;

   // Addresses at or beyond DEPTH are holes when DEPTH is not a power of two.
   assign wr_hit     = wr_en && (int'(wr_addr) < DEPTH);
   assign do_restore = ctx_restore && ctx_valid_q;

   always_comb begin
      wr_cur = '0;
      for (int i = 0; i < DEPTH; i++)
         if (wr_addr == AW'(i)) wr_cur = live_q[i];
   end

   cpu_reg_update #(.WIDTH(WIDTH)) u_update (
      .op_i     (wr_op),
      .cur_i    (wr_cur),
      .data_i   (wr_data),
      .result_o (upd_result),
      .zero_o   (upd_zero),
      .carry_o  (upd_carry)
   );

   always_comb begin
      rd_a_data = '0;
      rd_b_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_a_addr == AW'(i)) rd_a_data = live_q[i];
         if (rd_b_addr == AW'(i)) rd_b_data = live_q[i];
      end
      if (BYPASS != 0 && wr_hit && rd_a_addr == wr_addr) rd_a_data = upd_result;
      if (BYPASS != 0 && wr_hit && rd_b_addr == wr_addr) rd_b_data = upd_result;
   end

   // Restore/swap selects the base image first; a same-cycle write then overrides it.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         live_d[i]   = do_restore ? shadow_q[i] : live_q[i];
         shadow_d[i] = ctx_save   ? live_q[i]   : shadow_q[i];
      end
      flags_d        = do_restore ? shadow_flags_q : flags_q;
      shadow_flags_d = ctx_save   ? flags_q        : shadow_flags_q;

      if (wr_hit) begin
         for (int i = 0; i < DEPTH; i++)
            if (wr_addr == AW'(i)) live_d[i] = upd_result;
         flags_d = '{zero: upd_zero, carry: upd_carry};
      end

      ctx_valid_d = ctx_valid_q;
      if (ctx_save)        ctx_valid_d = 1'b1;
      else if (do_restore) ctx_valid_d = 1'b0;

      ctx_err_d = ctx_restore && !ctx_valid_q;
   end

   // NOTE: state uses non-blocking assignments; both banks are cleared by reset since software reads them.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            live_q[i]   <= '0;
            shadow_q[i] <= '0;
         end
         flags_q        <= '0;
         shadow_flags_q <= '0;
         ctx_valid_q    <= 1'b0;
         ctx_err_q      <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            live_q[i]   <= live_d[i];
            shadow_q[i] <= shadow_d[i];
         end
         flags_q        <= flags_d;
         shadow_flags_q <= shadow_flags_d;
         ctx_valid_q    <= ctx_valid_d;
         ctx_err_q      <= ctx_err_d;
      end
   end

   assign ctx_valid  = ctx_valid_q;
   assign ctx_err    = ctx_err_q;
   assign flag_zero  = flags_q.zero;
   assign flag_carry = flags_q.carry;

endmodule

// File: tb/tb_cpu_register_file.sv
// Directed bench: three register files (bypass, no-bypass, DEPTH=3) share one
// stimulus stream; each test task checks hand-computed values.
module tb_cpu_register_file;

   logic       clock;
   logic       reset;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [1:0] wr_op;
   logic [7:0] wr_data;
   logic [1:0] rd_a_addr;
   logic [1:0] rd_b_addr;
   logic       ctx_save;
   logic       ctx_restore;

   logic [7:0] m_rd_a, m_rd_b, n_rd_a, n_rd_b, t_rd_a, t_rd_b;
   logic       m_valid, m_err, m_zero, m_carry;
   logic       n_valid, n_err, n_zero, n_carry;
   logic       t_valid, t_err, t_zero, t_carry;

   int vectors;
   int miscompares;

   cpu_register_file #(.WIDTH(8), .DEPTH(4), .BYPASS(1)) dut_main (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_op(wr_op),
      .wr_data(wr_data), .rd_a_addr(rd_a_addr), .rd_a_data(m_rd_a), .rd_b_addr(rd_b_addr),
      .rd_b_data(m_rd_b), .ctx_save(ctx_save), .ctx_restore(ctx_restore), .ctx_valid(m_valid),
      .ctx_err(m_err), .flag_zero(m_zero), .flag_carry(m_carry)
   );

   cpu_register_file #(.WIDTH(8), .DEPTH(4), .BYPASS(0)) dut_nobyp (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_op(wr_op),
      .wr_data(wr_data), .rd_a_addr(rd_a_addr), .rd_a_data(n_rd_a), .rd_b_addr(rd_b_addr),
      .rd_b_data(n_rd_b), .ctx_save(ctx_save), .ctx_restore(ctx_restore), .ctx_valid(n_valid),
      .ctx_err(n_err), .flag_zero(n_zero), .flag_carry(n_carry)
   );

   cpu_register_file #(.WIDTH(8), .DEPTH(3), .BYPASS(1)) dut_d3 (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_op(wr_op),
      .wr_data(wr_data), .rd_a_addr(rd_a_addr), .rd_a_data(t_rd_a), .rd_b_addr(rd_b_addr),
      .rd_b_data(t_rd_b), .ctx_save(ctx_save), .ctx_restore(ctx_restore), .ctx_valid(t_valid),
      .ctx_err(t_err), .flag_zero(t_zero), .flag_carry(t_carry)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge, then drop all one-shot controls so reads settle.
   task automatic tick;
      @(posedge clock);
      #1;
      wr_en       = 1'b0;
      ctx_save    = 1'b0;
      ctx_restore = 1'b0;
      reset       = 1'b0;
      #1;
   endtask

   task automatic drive_wr(input logic [1:0] addr, input logic [1:0] op, input logic [7:0] data);
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_op   = op;
      wr_data = data;
   endtask

   task automatic set_rd(input logic [1:0] a, input logic [1:0] b);
      rd_a_addr = a;
      rd_b_addr = b;
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         set_rd(2'(i), 2'(i));
         vectors++;
         if (m_rd_a !== 8'h00 || m_rd_b !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_read r%0d: got a=%h b=%h want 00", i, m_rd_a, m_rd_b);
         end
      end
      vectors++;
      if ({m_zero, m_carry, m_valid, m_err} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_status: got zcve=%b want 0000", {m_zero, m_carry, m_valid, m_err});
      end
   endtask

   task automatic test_inc_dec;
      drive_wr(2'd1, 2'b00, 8'hFF);
      tick();
      set_rd(2'd1, 2'd0);
      vectors++;
      if (m_rd_a !== 8'hFF || {m_zero, m_carry} !== 2'b00) begin
         miscompares++;
         $display("FAIL load_ff: got r1=%h zc=%b want ff 00", m_rd_a, {m_zero, m_carry});
      end
      drive_wr(2'd1, 2'b01, 8'h00);
      tick();
      vectors++;
      if (m_rd_a !== 8'h00 || {m_zero, m_carry} !== 2'b11) begin
         miscompares++;
         $display("FAIL inc_wrap: got r1=%h zc=%b want 00 11", m_rd_a, {m_zero, m_carry});
      end
      drive_wr(2'd1, 2'b10, 8'h00);
      tick();
      vectors++;
      if (m_rd_a !== 8'hFF || {m_zero, m_carry} !== 2'b01) begin
         miscompares++;
         $display("FAIL dec_wrap: got r1=%h zc=%b want ff 01", m_rd_a, {m_zero, m_carry});
      end
   endtask

   task automatic test_bypass;
      rd_a_addr = 2'd2;
      rd_b_addr = 2'd1;
      drive_wr(2'd2, 2'b00, 8'h5A);
      #1;
      vectors++;
      if (m_rd_a !== 8'h5A) begin
         miscompares++;
         $display("FAIL bypass_on: got %h want 5a", m_rd_a);
      end
      vectors++;
      if (n_rd_a !== 8'h00) begin
         miscompares++;
         $display("FAIL bypass_off: got %h want 00", n_rd_a);
      end
      vectors++;
      if (m_rd_b !== 8'hFF) begin
         miscompares++;
         $display("FAIL bypass_other_port: got %h want ff", m_rd_b);
      end
      tick();
      vectors++;
      if (n_rd_a !== 8'h5A) begin
         miscompares++;
         $display("FAIL bypass_off_after_edge: got %h want 5a", n_rd_a);
      end
   endtask

   task automatic test_save_restore;
      drive_wr(2'd0, 2'b00, 8'h11);
      tick();
      ctx_save = 1'b1;
      tick();
      vectors++;
      if (m_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL save_valid: got %b want 1", m_valid);
      end
      drive_wr(2'd0, 2'b00, 8'h22);
      tick();
      drive_wr(2'd2, 2'b11, 8'h00);
      tick();
      set_rd(2'd0, 2'd2);
      vectors++;
      if (m_rd_a !== 8'h22 || m_rd_b !== 8'h00 || m_zero !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_restore: got r0=%h r2=%h z=%b want 22 00 1", m_rd_a, m_rd_b, m_zero);
      end
      ctx_restore = 1'b1;
      tick();
      vectors++;
      if (m_rd_a !== 8'h11 || m_rd_b !== 8'h5A || m_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL restore: got r0=%h r2=%h z=%b want 11 5a 0", m_rd_a, m_rd_b, m_zero);
      end
      vectors++;
      if (m_valid !== 1'b0 || m_err !== 1'b0) begin
         miscompares++;
         $display("FAIL restore_status: got valid=%b err=%b want 0 0", m_valid, m_err);
      end
      ctx_restore = 1'b1;
      tick();
      vectors++;
      if (m_err !== 1'b1 || m_rd_a !== 8'h11) begin
         miscompares++;
         $display("FAIL restore_empty: got err=%b r0=%h want 1 11", m_err, m_rd_a);
      end
      tick();
      vectors++;
      if (m_err !== 1'b0) begin
         miscompares++;
         $display("FAIL err_pulse_width: got %b want 0", m_err);
      end
   endtask

   task automatic test_swap;
      drive_wr(2'd3, 2'b00, 8'h33);
      tick();
      ctx_save = 1'b1;
      tick();
      drive_wr(2'd3, 2'b00, 8'h44);
      tick();
      ctx_save    = 1'b1;
      ctx_restore = 1'b1;
      tick();
      set_rd(2'd3, 2'd0);
      vectors++;
      if (m_rd_a !== 8'h33 || m_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL swap: got r3=%h valid=%b want 33 1", m_rd_a, m_valid);
      end
      ctx_restore = 1'b1;
      tick();
      vectors++;
      if (m_rd_a !== 8'h44 || m_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL swap_shadow: got r3=%h valid=%b want 44 0", m_rd_a, m_valid);
      end
      ctx_save = 1'b1;
      tick();
      ctx_save    = 1'b1;
      ctx_restore = 1'b1;
      drive_wr(2'd3, 2'b00, 8'h77);
      tick();
      vectors++;
      if (m_rd_a !== 8'h77 || m_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL swap_write: got r3=%h valid=%b want 77 1", m_rd_a, m_valid);
      end
      ctx_restore = 1'b1;
      tick();
      vectors++;
      if (m_rd_a !== 8'h44) begin
         miscompares++;
         $display("FAIL swap_write_shadow: got r3=%h want 44", m_rd_a);
      end
   endtask

   task automatic test_out_of_range;
      drive_wr(2'd1, 2'b00, 8'h00);
      tick();
      vectors++;
      if (t_zero !== 1'b1 || t_carry !== 1'b0) begin
         miscompares++;
         $display("FAIL d3_setup_flags: got zc=%b want 10", {t_zero, t_carry});
      end
      rd_a_addr = 2'd3;
      rd_b_addr = 2'd3;
      drive_wr(2'd3, 2'b00, 8'h99);
      #1;
      vectors++;
      if (t_rd_a !== 8'h00 || m_rd_a !== 8'h99) begin
         miscompares++;
         $display("FAIL oor_bypass: got d3=%h main=%h want 00 99", t_rd_a, m_rd_a);
      end
      tick();
      vectors++;
      if (t_rd_b !== 8'h00 || t_zero !== 1'b1 || m_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL oor_write: got d3=%h d3z=%b mainz=%b want 00 1 0", t_rd_b, t_zero, m_zero);
      end
      drive_wr(2'd3, 2'b10, 8'h00);
      tick();
      vectors++;
      if ({t_zero, t_carry} !== 2'b10 || t_rd_a !== 8'h00) begin
         miscompares++;
         $display("FAIL oor_dec: got zc=%b rd=%h want 10 00", {t_zero, t_carry}, t_rd_a);
      end
   endtask

   task automatic test_reset_during_restore;
      ctx_save = 1'b1;
      tick();
      vectors++;
      if (m_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_setup_valid: got %b want 1", m_valid);
      end
      reset       = 1'b1;
      ctx_restore = 1'b1;
      drive_wr(2'd0, 2'b00, 8'hAA);
      tick();
      for (int i = 0; i < 4; i++) begin
         set_rd(2'(i), 2'(i));
         vectors++;
         if (m_rd_a !== 8'h00 || m_rd_b !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_restore_read r%0d: got a=%h b=%h want 00", i, m_rd_a, m_rd_b);
         end
      end
      vectors++;
      if ({m_zero, m_carry, m_valid, m_err} !== 4'b0000) begin
         miscompares++;
         $display("FAIL rst_restore_status: got zcve=%b want 0000", {m_zero, m_carry, m_valid, m_err});
      end
      ctx_restore = 1'b1;
      tick();
      vectors++;
      if (m_err !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_restore_err: got %b want 1", m_err);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      wr_en       = 1'b0;
      wr_addr     = 2'd0;
      wr_op       = 2'b00;
      wr_data     = 8'h00;
      rd_a_addr   = 2'd0;
      rd_b_addr   = 2'd0;
      ctx_save    = 1'b0;
      ctx_restore = 1'b0;
      tick();
      test_reset();
      test_inc_dec();
      test_bypass();
      test_save_restore();
      test_swap();
      test_out_of_range();
      test_reset_during_restore();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
